// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two requester FIFOs (ALU, load path) round-robin into the 8x16 register file.
// Optional macro WB_ARB_R0_DISCARD_EN makes register 0 hardwired zero (its writes are dropped).
module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_rw,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_rw,
    input  logic [DATA_W-1:0] wb1_data,
    output logic [ADDR_W-1:0] rw_out,
    output logic [DATA_W-1:0] bus_w1,
    output logic [DATA_W-1:0] bus_w2,
    output logic              sig_enable_write1,
    output logic              sig_enable_write2,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic              hit_a,
    output logic              hit_b,
    output logic              busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef WB_ARB_R0_DISCARD_EN
    localparam bit R0_DISCARD = 1'b1;
`else
    localparam bit R0_DISCARD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] rw_q;
    logic [DATA_W-1:0] bus_w1_q, bus_w2_q;

    logic [ADDR_W-1:0] mem_rw_q   [2][DEPTH];
    logic [DATA_W-1:0] mem_data_q [2][DEPTH];
    logic [DEPTH-1:0]  slot_vld_q [2];
    logic [PTR_W-1:0]  rptr_q     [2];
    logic [PTR_W-1:0]  wptr_q     [2];
    logic [CNT_W-1:0]  cnt_q      [2];

    logic [1:0]        in_valid, full, empty, push, pop;
    logic [ADDR_W-1:0] in_rw   [2];
    logic [DATA_W-1:0] in_data [2];
    logic              gnt_sel;
    logic [ADDR_W-1:0] gnt_rw;
    logic [DATA_W-1:0] gnt_data;

    assign in_valid   = {wb1_valid, wb0_valid};
    assign in_rw[0]   = wb0_rw;
    assign in_rw[1]   = wb1_rw;
    assign in_data[0] = wb0_data;
    assign in_data[1] = wb1_data;

    // Ready depends on occupancy only, so a full FIFO refuses even while it is being popped.
    assign full  = {cnt_q[1] == CNT_W'(DEPTH), cnt_q[0] == CNT_W'(DEPTH)};
    assign empty = {cnt_q[1] == '0, cnt_q[0] == '0};
    assign push  = in_valid & ~full;
    assign pop   = {state_d == GRANT1, state_d == GRANT0};

    assign wb0_ready = ~full[0];
    assign wb1_ready = ~full[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 2; r++) begin
                rptr_q[r]     <= '0;
                wptr_q[r]     <= '0;
                cnt_q[r]      <= '0;
                slot_vld_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (pop[r]) begin
                    slot_vld_q[r][rptr_q[r]] <= 1'b0;
                    rptr_q[r]                <= rptr_q[r] + 1'b1;
                end
                if (push[r]) begin
                    slot_vld_q[r][wptr_q[r]] <= 1'b1;
                    wptr_q[r]                <= wptr_q[r] + 1'b1;
                end
                if (push[r] != pop[r]) begin
                    cnt_q[r] <= push[r] ? cnt_q[r] + 1'b1 : cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // NOTE: payload storage is deliberately not reset; slot_vld_q alone says which entries are live.
    always_ff @(posedge clock) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                mem_rw_q[r][wptr_q[r]]   <= in_rw[r];
                mem_data_q[r][wptr_q[r]] <= in_data[r];
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = IDLE;
        rr_d    = rr_q;
        if (!empty[0] && !empty[1]) begin
            state_d = rr_q ? GRANT1 : GRANT0;
            rr_d    = ~rr_q;
        end else if (!empty[0]) begin
            state_d = GRANT0;
            rr_d    = 1'b1;
        end else if (!empty[1]) begin
            state_d = GRANT1;
            rr_d    = 1'b0;
        end
    end

    assign gnt_sel  = (state_d == GRANT1);
    assign gnt_rw   = mem_rw_q[gnt_sel][rptr_q[gnt_sel]];
    assign gnt_data = mem_data_q[gnt_sel][rptr_q[gnt_sel]];
    assign drop_d   = R0_DISCARD && (state_d != IDLE) && (gnt_rw == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            drop_q   <= 1'b0;
            rw_q     <= '0;
            bus_w1_q <= '0;
            bus_w2_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            drop_q  <= drop_d;
            if (state_d != IDLE && !drop_d) rw_q <= gnt_rw;
            if (state_d == GRANT0 && !drop_d) bus_w1_q <= gnt_data;
            if (state_d == GRANT1 && !drop_d) bus_w2_q <= gnt_data;
        end
    end

    assign rw_out            = rw_q;
    assign bus_w1            = bus_w1_q;
    assign bus_w2            = bus_w2_q;
    assign sig_enable_write1 = (state_q == GRANT0) && !drop_q;
    assign sig_enable_write2 = (state_q == GRANT1) && !drop_q;
    assign busy              = !empty[0] || !empty[1] || sig_enable_write1 || sig_enable_write2;

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_vld_q[r][i] && !(R0_DISCARD && mem_rw_q[r][i] == '0)) begin
                    if (mem_rw_q[r][i] == ra) hit_a = 1'b1;
                    if (mem_rw_q[r][i] == rb) hit_b = 1'b1;
                end
            end
        end
        if (sig_enable_write1 || sig_enable_write2) begin
            if (rw_q == ra) hit_a = 1'b1;
            if (rw_q == rb) hit_b = 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-requester scoreboard queues filled on accept, drained on enable.
module tb_regfile_wb_arbiter;
    localparam int DEPTH  = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
`ifdef WB_ARB_R0_DISCARD_EN
    localparam bit R0_DISC = 1'b1;
`else
    localparam bit R0_DISC = 1'b0;
`endif

    typedef logic [ADDR_W+DATA_W-1:0] wr_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [ADDR_W-1:0] wb0_rw, wb1_rw, rw_out, ra, rb;
    logic [DATA_W-1:0] wb0_data, wb1_data, bus_w1, bus_w2;
    logic              sig_enable_write1, sig_enable_write2, hit_a, hit_b, busy;

    int  n_cmp = 0;
    int  n_err = 0;
    wr_t exp_q0[$];
    wr_t exp_q1[$];
    int  grant_log[$];
    logic [DATA_W-1:0] last_w2 = '0;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rw(wb0_rw), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rw(wb1_rw), .wb1_data(wb1_data),
        .rw_out(rw_out), .bus_w1(bus_w1), .bus_w2(bus_w2),
        .sig_enable_write1(sig_enable_write1), .sig_enable_write2(sig_enable_write2),
        .ra(ra), .rb(rb), .hit_a(hit_a), .hit_b(hit_b), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each enable against the oldest expected write, then record new accepts.
    always @(negedge clock) begin : monitor
        wr_t e;
        check("en_onehot", 32'(sig_enable_write1 && sig_enable_write2), 0);
        if (sig_enable_write1) begin
            grant_log.push_back(1);
            check("w1_expected", 32'(exp_q0.size() > 0), 1);
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("w1_rw", 32'(rw_out), 32'(e[DATA_W +: ADDR_W]));
                check("w1_data", 32'(bus_w1), 32'(e[DATA_W-1:0]));
            end
        end
        if (sig_enable_write2) begin
            grant_log.push_back(2);
            last_w2 = bus_w2;
            check("w2_expected", 32'(exp_q1.size() > 0), 1);
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("w2_rw", 32'(rw_out), 32'(e[DATA_W +: ADDR_W]));
                check("w2_data", 32'(bus_w2), 32'(e[DATA_W-1:0]));
            end
        end
        if (reset_n && wb0_valid && wb0_ready && !(R0_DISC && wb0_rw == '0))
            exp_q0.push_back({wb0_rw, wb0_data});
        if (reset_n && wb1_valid && wb1_ready && !(R0_DISC && wb1_rw == '0))
            exp_q1.push_back({wb1_rw, wb1_data});
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        tick();
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 0);
    endtask

    initial begin : stim
        int  i0, i1, n, log0;
        bit  a0, a1;
        idle_inputs();
        wb0_rw = '0; wb0_data = '0; wb1_rw = '0; wb1_data = '0;
        ra = '0; rb = '0;

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("rst_ready0", 32'(wb0_ready), 1);
        check("rst_ready1", 32'(wb1_ready), 1);
        check("rst_en1", 32'(sig_enable_write1), 0);
        check("rst_en2", 32'(sig_enable_write2), 0);
        check("rst_rw_out", 32'(rw_out), 0);
        check("rst_bus_w1", 32'(bus_w1), 0);
        check("rst_bus_w2", 32'(bus_w2), 0);
        check("rst_hit_a", 32'(hit_a), 0);
        check("rst_hit_b", 32'(hit_b), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Single write: accepted at edge 1, enable visible in cycle 2, idle in cycle 3
        wb0_valid = 1'b1; wb0_rw = 3'd1; wb0_data = 16'd8;
        tick();
        idle_inputs();
        check("t1_busy_queued", 32'(busy), 1);
        check("t1_en1_early", 32'(sig_enable_write1), 0);
        tick();
        check("t1_en1", 32'(sig_enable_write1), 1);
        check("t1_en2", 32'(sig_enable_write2), 0);
        check("t1_rw_out", 32'(rw_out), 1);
        check("t1_bus_w1", 32'(bus_w1), 8);
        tick();
        check("t1_en1_off", 32'(sig_enable_write1), 0);
        check("t1_en2_off", 32'(sig_enable_write2), 0);
        check("t1_busy_off", 32'(busy), 0);

        // Contention: both requesters stream 6 writes; grants must alternate starting with port 1
        do_reset();
        log0 = grant_log.size();
        i0 = 0; i1 = 0; n = 0;
        while ((i0 < 6 || i1 < 6) && n < 40) begin
            wb0_valid = (i0 < 6); wb0_rw = 3'd2; wb0_data = 16'(10 + i0);
            wb1_valid = (i1 < 6); wb1_rw = 3'd3; wb1_data = 16'(20 + i1);
            a0 = wb0_valid && wb0_ready;
            a1 = wb1_valid && wb1_ready;
            tick();
            if (a0) i0++;
            if (a1) i1++;
            n++;
        end
        idle_inputs();
        check("t2_all_accepted", 32'(i0 + i1), 12);
        wait_idle("t2_drain");
        check("t2_grant_count", 32'(grant_log.size() - log0), 12);
        for (int k = 0; k < 12; k++) begin
            if (log0 + k < grant_log.size())
                check($sformatf("t2_order%0d", k), 32'(grant_log[log0 + k]), (k % 2 == 1) ? 2 : 1);
        end

        // Backpressure: FIFO 1 fills after 2 accepts; the third write waits for a free slot
        do_reset();
        wb0_valid = 1'b1; wb0_rw = 3'd7; wb0_data = 16'h50;
        wb1_valid = 1'b1; wb1_rw = 3'd6; wb1_data = 16'h40;
        check("t3_ready_empty", 32'(wb1_ready), 1);
        tick();
        wb0_data = 16'h51; wb1_data = 16'h41;
        tick();
        check("t3_full", 32'(wb1_ready), 0);
        wb0_valid = 1'b0; wb1_data = 16'h42;
        tick();
        check("t3_slot_freed", 32'(wb1_ready), 1);
        tick();
        idle_inputs();
        wait_idle("t3_drain");
        check("t3_third_written", 32'(last_w2), 32'h42);

        // Hazard flags: hit_a from accept through the enable cycle, clear afterwards
        do_reset();
        ra = 3'd5; rb = 3'd4;
        wb1_valid = 1'b1; wb1_rw = 3'd5; wb1_data = 16'h77;
        check("t4_hit_pre", 32'(hit_a), 0);
        tick();
        idle_inputs();
        check("t4_hit_queued", 32'(hit_a), 1);
        check("t4_hitb_queued", 32'(hit_b), 0);
        tick();
        check("t4_en2", 32'(sig_enable_write2), 1);
        check("t4_hit_inflight", 32'(hit_a), 1);
        check("t4_hitb_inflight", 32'(hit_b), 0);
        tick();
        check("t4_hit_after", 32'(hit_a), 0);
        check("t4_hitb_after", 32'(hit_b), 0);
        ra = '0; rb = '0;

        // Reset mid-operation: queued writes are discarded
        do_reset();
        wb0_valid = 1'b1; wb0_rw = 3'd1; wb0_data = 16'h11;
        wb1_valid = 1'b1; wb1_rw = 3'd3; wb1_data = 16'h33;
        tick();
        wb1_valid = 1'b0; wb0_rw = 3'd2; wb0_data = 16'h22;
        tick();
        idle_inputs();
        reset_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check("t5_en1", 32'(sig_enable_write1), 0);
        check("t5_en2", 32'(sig_enable_write2), 0);
        check("t5_rw_out", 32'(rw_out), 0);
        check("t5_bus_w1", 32'(bus_w1), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_ready0", 32'(wb0_ready), 1);
        log0 = grant_log.size();
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) tick();
        check("t5_no_pulse", 32'(grant_log.size() - log0), 0);
        check("t5_busy_after", 32'(busy), 0);

        // Register 0 write (discarded only when the optional feature is built in)
        do_reset();
        wb0_valid = 1'b1; wb0_rw = 3'd4; wb0_data = 16'h1;
        tick();
        idle_inputs();
        tick();
        tick();
        ra = '0;
        wb0_valid = 1'b1; wb0_rw = 3'd0; wb0_data = 16'd32;
        check("t6_ready", 32'(wb0_ready), 1);
        tick();
        idle_inputs();
        check("t6_hit_a", 32'(hit_a), R0_DISC ? 0 : 1);
        tick();
`ifdef WB_ARB_R0_DISCARD_EN
        check("t6_en1", 32'(sig_enable_write1), 0);
        check("t6_rw_out", 32'(rw_out), 4);
        check("t6_bus_w1", 32'(bus_w1), 1);
        check("t6_hit_drop", 32'(hit_a), 0);
`else
        check("t6_en1", 32'(sig_enable_write1), 1);
        check("t6_rw_out", 32'(rw_out), 0);
        check("t6_bus_w1", 32'(bus_w1), 32);
        check("t6_hit_inflight", 32'(hit_a), 1);
`endif
        check("t6_en2", 32'(sig_enable_write2), 0);
        tick();
        check("t6_en1_off", 32'(sig_enable_write1), 0);
        check("t6_busy_off", 32'(busy), 0);

        check("final_q0_empty", 32'(exp_q0.size()), 0);
        check("final_q1_empty", 32'(exp_q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
